rdma_wr_demux_nch: RTL and testbench

- Parametrised N-channel RDMA write demultiplexer: steers write commands and their payload beats from one network-side stream to N_CH per-region outputs.
- Each channel has its own data FIFO and a fill-threshold ready flag for upstream flow control.
- Supports arbitrary data width, sequencing depth and FIFO depth.
- Adds explicit zero-length handling, discard of commands addressed to a non-existent channel, and back-to-back command switching without idle cycles.
- Sits between the RDMA write-data path and the per-region user write ports.

---
 rtl/rdma_wr_demux_nch_if.sv | 58 +++++
 rtl/rdma_wr_demux_nch.sv | 251 +++++++++++++++++++++++++
 tb/tb_rdma_wr_demux_nch.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdma_wr_demux_nch_if.sv
// Bus bundle for rdma_wr_demux_nch: upstream command/data streams and per-channel outputs.
// slave = demux side, master = upstream/downstream environment side.
interface rdma_wr_demux_nch_if #(
   parameter int N_CH      = 4,
   parameter int CH_BITS   = 2,
   parameter int DATA_BITS = 512,
   parameter int LEN_BITS  = 28,
   parameter int REQ_BITS  = 128
);
   localparam int KEEP_BITS = DATA_BITS / 8;

   // Every channel obeys valid/ready: a transfer happens on a rising edge where both are
   // high; valid never waits on ready, and payload holds steady while valid is unaccepted.
   logic                        s_req_valid;
   logic                        s_req_ready;
   logic [REQ_BITS-1:0]         s_req_data;
   logic [CH_BITS-1:0]          s_req_vfid;
   logic [LEN_BITS-1:0]         s_req_len;
   logic                        s_req_last;

   logic [N_CH-1:0]             m_req_valid;
   logic [N_CH-1:0]             m_req_ready;
   logic [REQ_BITS-1:0]         m_req_data;

   logic                        s_axis_tvalid;
   logic                        s_axis_tready;
   logic                        s_axis_tlast;
   logic [DATA_BITS-1:0]        s_axis_tdata;
   logic [KEEP_BITS-1:0]        s_axis_tkeep;

   logic [N_CH-1:0]             m_axis_tvalid;
   logic [N_CH-1:0]             m_axis_tready;
   logic [N_CH-1:0]             m_axis_tlast;
   logic [N_CH*DATA_BITS-1:0]   m_axis_tdata;
   logic [N_CH*KEEP_BITS-1:0]   m_axis_tkeep;

   modport slave (
      input  s_req_valid, s_req_data, s_req_vfid, s_req_len, s_req_last,
      output s_req_ready,
      output m_req_valid, m_req_data,
      input  m_req_ready,
      input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
      output s_axis_tready,
      output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
      input  m_axis_tready
   );

   modport master (
      output s_req_valid, s_req_data, s_req_vfid, s_req_len, s_req_last,
      input  s_req_ready,
      input  m_req_valid, m_req_data,
      output m_req_ready,
      output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
      input  s_axis_tready,
      input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
      output m_axis_tready
   );
endinterface

// File: rtl/rdma_wr_demux_nch.sv
// N-channel RDMA write demux: steers commands and payload beats into per-channel FWFT FIFOs.
// Define RDMA_WR_DEMUX_STATS_EN to add per-channel beat/command counters (stat_beats, stat_cmds).
module rdma_wr_demux_nch #(
   parameter int N_CH       = 4,
   parameter int CH_BITS    = 2,
   parameter int DATA_BITS  = 512,
   parameter int LEN_BITS   = 28,
   parameter int REQ_BITS   = 128,
   parameter int SEQ_DEPTH  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int RDY_THRS   = 48
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   rdma_wr_demux_nch_if.slave   bus,
   output logic [N_CH-1:0]      m_wr_rdy,
   output logic                 err_bad_vfid,
   output logic [15:0]          drop_cnt,
   output logic [1:0]           dbg_state_o
`ifdef RDMA_WR_DEMUX_STATS_EN
   ,
   output logic [N_CH*32-1:0]   stat_beats,
   output logic [N_CH*16-1:0]   stat_cmds
`endif
);
   localparam int KEEP_BITS = DATA_BITS / 8;
   localparam int BEAT_LOG  = $clog2(DATA_BITS / 8);
   localparam int CNT_W     = LEN_BITS - BEAT_LOG + 1;
   localparam int ENT_W     = 2 + CH_BITS + CNT_W;
   localparam int SEQ_AW    = $clog2(SEQ_DEPTH);
   localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
   localparam int FW        = DATA_BITS + KEEP_BITS + 1;
   localparam logic [SEQ_AW:0]  SEQ_FULL  = (SEQ_AW+1)'(SEQ_DEPTH);
   localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW:0] THRS      = (FIFO_AW+1)'(RDY_THRS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUX  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   // ---------------- command path ----------------
   logic [N_CH-1:0]      sel_oh;
   logic                 vfid_ok;
   logic                 seq_ready;
   logic                 req_ready_c;
   logic [N_CH-1:0]      req_valid_c;
   logic                 req_fire;
   logic                 seq_push;
   logic [LEN_BITS:0]    len_round;
   logic [CNT_W-1:0]     beats_m1;

   always_comb begin
      sel_oh = '0;
      for (int c = 0; c < N_CH; c++) begin
         sel_oh[c] = (bus.s_req_vfid == CH_BITS'(c));
      end
   end

   assign vfid_ok     = |sel_oh;
   assign req_ready_c = aresetn & seq_ready & (vfid_ok ? |(sel_oh & bus.m_req_ready) : 1'b1);
   assign req_valid_c = aresetn ? (sel_oh & {N_CH{bus.s_req_valid & seq_ready}}) : '0;
   assign req_fire    = bus.s_req_valid & req_ready_c;
   assign seq_push    = req_fire & (bus.s_req_len != '0);

   // One spare bit on the rounded length keeps ceil(len/BEAT_BYTES) from wrapping.
   assign len_round = {1'b0, bus.s_req_len} + (LEN_BITS+1)'((DATA_BITS / 8) - 1);
   assign beats_m1  = len_round[LEN_BITS:BEAT_LOG] - CNT_ONE;

   assign bus.s_req_ready = req_ready_c;
   assign bus.m_req_valid = req_valid_c;
   assign bus.m_req_data  = bus.s_req_data;

   // ---------------- sequence queue ----------------
   logic [ENT_W-1:0]  seq_mem_q [SEQ_DEPTH];
   logic [SEQ_AW:0]   seq_wr_q, seq_rd_q;
   logic              seq_empty;
   logic              seq_pop;
   logic              e_drop, e_last;
   logic [CH_BITS-1:0] e_vfid;
   logic [CNT_W-1:0]  e_cnt;

   assign seq_ready = ((seq_wr_q - seq_rd_q) != SEQ_FULL);
   assign seq_empty = (seq_wr_q == seq_rd_q);
   assign {e_drop, e_last, e_vfid, e_cnt} = seq_mem_q[seq_rd_q[SEQ_AW-1:0]];

   // ---------------- beat FSM ----------------
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CH_BITS-1:0] vfid_q, vfid_d;
   logic               last_q, last_d;
   logic [N_CH-1:0]    cur_oh;
   logic [N_CH-1:0]    fifo_ready;
   logic               s_tready_c;
   logic               beat_fire;
   logic               out_tlast;

   always_comb begin
      cur_oh = '0;
      for (int c = 0; c < N_CH; c++) begin
         cur_oh[c] = (vfid_q == CH_BITS'(c));
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      vfid_d     = vfid_q;
      last_d     = last_q;
      seq_pop    = 1'b0;
      s_tready_c = 1'b0;
      case (state_q)
         ST_MUX:  s_tready_c = |(cur_oh & fifo_ready);
         ST_DROP: s_tready_c = 1'b1;
         default: s_tready_c = 1'b0;
      endcase
      if (!aresetn) s_tready_c = 1'b0;
      beat_fire = bus.s_axis_tvalid & s_tready_c;
      // The final beat of an entry hands straight over to the next queued entry.
      if ((state_q == ST_IDLE) || (beat_fire && (cnt_q == '0))) begin
         if (!seq_empty) begin
            seq_pop = 1'b1;
            state_d = e_drop ? ST_DROP : ST_MUX;
            cnt_d   = e_cnt;
            vfid_d  = e_vfid;
            last_d  = e_last;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (beat_fire) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   assign out_tlast         = (cnt_q == '0) & last_q;
   assign bus.s_axis_tready = s_tready_c;
   assign dbg_state_o       = state_q;

   // ---------------- per-channel FIFOs ----------------
   logic [FW-1:0]      fifo_mem_q [N_CH][FIFO_DEPTH];
   logic [FIFO_AW:0]   f_wr_q [N_CH];
   logic [FIFO_AW:0]   f_rd_q [N_CH];
   logic [FIFO_AW:0]   f_cnt  [N_CH];
   logic [N_CH-1:0]    f_push, f_pop, f_valid;
   logic [N_CH-1:0]    wr_rdy_q;
   logic [N_CH-1:0]    m_tlast_c;
   logic [N_CH*DATA_BITS-1:0] m_tdata_c;
   logic [N_CH*KEEP_BITS-1:0] m_tkeep_c;

   always_comb begin
      m_tlast_c = '0;
      m_tdata_c = '0;
      m_tkeep_c = '0;
      for (int c = 0; c < N_CH; c++) begin
         f_cnt[c]      = f_wr_q[c] - f_rd_q[c];
         fifo_ready[c] = (f_cnt[c] != FIFO_FULL);
         f_valid[c]    = aresetn & (f_cnt[c] != '0);
         f_push[c]     = (state_q == ST_MUX) & beat_fire & cur_oh[c];
         f_pop[c]      = f_valid[c] & bus.m_axis_tready[c];
         {m_tlast_c[c], m_tkeep_c[c*KEEP_BITS +: KEEP_BITS], m_tdata_c[c*DATA_BITS +: DATA_BITS]}
            = fifo_mem_q[c][f_rd_q[c][FIFO_AW-1:0]];
      end
   end

   assign bus.m_axis_tvalid = f_valid;
   assign bus.m_axis_tlast  = m_tlast_c;
   assign bus.m_axis_tdata  = m_tdata_c;
   assign bus.m_axis_tkeep  = m_tkeep_c;
   assign m_wr_rdy          = wr_rdy_q;

   // ---------------- control registers ----------------
   logic        err_q;
   logic [15:0] drop_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         vfid_q   <= '0;
         last_q   <= 1'b0;
         seq_wr_q <= '0;
         seq_rd_q <= '0;
         err_q    <= 1'b0;
         drop_q   <= '0;
         wr_rdy_q <= '1;
         for (int c = 0; c < N_CH; c++) begin
            f_wr_q[c] <= '0;
            f_rd_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vfid_q  <= vfid_d;
         last_q  <= last_d;
         if (seq_push) seq_wr_q <= seq_wr_q + 1'b1;
         if (seq_pop)  seq_rd_q <= seq_rd_q + 1'b1;
         if (req_fire && !vfid_ok) err_q <= 1'b1;
         if ((state_q == ST_DROP) && beat_fire && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
         for (int c = 0; c < N_CH; c++) begin
            if (f_push[c]) f_wr_q[c] <= f_wr_q[c] + 1'b1;
            if (f_pop[c])  f_rd_q[c] <= f_rd_q[c] + 1'b1;
            wr_rdy_q[c] <= (f_cnt[c] <= THRS);
         end
      end
   end

   // Storage arrays carry no reset; the pointers above define what is valid.
   always_ff @(posedge aclk) begin
      if (seq_push) begin
         seq_mem_q[seq_wr_q[SEQ_AW-1:0]] <= {~vfid_ok, bus.s_req_last, bus.s_req_vfid, beats_m1};
      end
      for (int c = 0; c < N_CH; c++) begin
         if (f_push[c]) begin
            fifo_mem_q[c][f_wr_q[c][FIFO_AW-1:0]] <= {out_tlast, bus.s_axis_tkeep, bus.s_axis_tdata};
         end
      end
   end

   assign err_bad_vfid = err_q;
   assign drop_cnt     = drop_q;

`ifdef RDMA_WR_DEMUX_STATS_EN
   logic [31:0] st_beats_q [N_CH];
   logic [15:0] st_cmds_q  [N_CH];

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int c = 0; c < N_CH; c++) begin
            st_beats_q[c] <= '0;
            st_cmds_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (f_pop[c]) st_beats_q[c] <= st_beats_q[c] + 32'd1;
            if (req_valid_c[c] && bus.m_req_ready[c]) st_cmds_q[c] <= st_cmds_q[c] + 16'd1;
         end
      end
   end

   always_comb begin
      stat_beats = '0;
      stat_cmds  = '0;
      for (int c = 0; c < N_CH; c++) begin
         stat_beats[c*32 +: 32] = st_beats_q[c];
         stat_cmds[c*16 +: 16]  = st_cmds_q[c];
      end
   end
`endif
endmodule

// File: tb/tb_rdma_wr_demux_nch.sv
// Randomized bench for rdma_wr_demux_nch: a command/beat reference model feeds per-channel
// expected queues that are compared against every output beat.
module tb_rdma_wr_demux_nch;
   localparam int N_CH       = 4;
   localparam int CH_BITS    = 3;
   localparam int DW         = 512;
   localparam int KW         = DW / 8;
   localparam int LEN_BITS   = 28;
   localparam int REQ_BITS   = 128;
   localparam int SEQ_DEPTH  = 16;
   localparam int FIFO_DEPTH = 64;
   localparam int RDY_THRS   = 48;
   localparam int FW         = DW + KW + 1;
   localparam int BB         = DW / 8;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic [N_CH-1:0]  m_wr_rdy;
   logic             err_bad_vfid;
   logic [15:0]      drop_cnt;
   logic [1:0]       dbg_state;

   rdma_wr_demux_nch_if #(.N_CH(N_CH), .CH_BITS(CH_BITS), .DATA_BITS(DW),
                          .LEN_BITS(LEN_BITS), .REQ_BITS(REQ_BITS)) bus ();

   rdma_wr_demux_nch #(.N_CH(N_CH), .CH_BITS(CH_BITS), .DATA_BITS(DW), .LEN_BITS(LEN_BITS),
                       .REQ_BITS(REQ_BITS), .SEQ_DEPTH(SEQ_DEPTH), .FIFO_DEPTH(FIFO_DEPTH),
                       .RDY_THRS(RDY_THRS)) dut (
      .aclk(aclk), .aresetn(aresetn), .bus(bus), .m_wr_rdy(m_wr_rdy),
      .err_bad_vfid(err_bad_vfid), .drop_cnt(drop_cnt), .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 aclk = ~aclk;

   // ---------------- scoreboard / model state ----------------
   typedef struct packed {
      logic [31:0] vfid;
      logic [31:0] beats;
      logic        last;
   } cmd_t;

   cmd_t            mcmd_q[$];
   logic [FW-1:0]   exp_q[N_CH][$];
   int              exp_req[N_CH];
   int              seen_req[N_CH];
   int              exp_drops = 0;
   logic            exp_err = 1'b0;
   logic [N_CH-1:0] hold_rdy = '0;
   int              n_checks = 0;
   int              n_fail = 0;
   int              b_vf[8], b_len[8];
   logic            b_last[8];
   int              nc, nb;

   task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_cmd(input int vfid, input int len, input logic last);
      cmd_t e;
      if (vfid < N_CH) exp_req[vfid]++;
      else exp_err = 1'b1;
      if (len > 0) begin
         e.vfid  = vfid;
         e.beats = (len + BB - 1) / BB;
         e.last  = last;
         mcmd_q.push_back(e);
      end
   endfunction

   task automatic model_beat(input logic [DW-1:0] d, input logic [KW-1:0] k);
      cmd_t e;
      if (mcmd_q.size() == 0) begin
         check("beat_without_cmd", bus.s_axis_tready, 1'b0);
      end else begin
         e = mcmd_q.pop_front();
         e.beats = e.beats - 1;
         if (e.vfid < N_CH) exp_q[e.vfid].push_back({(e.beats == 0) && e.last, k, d});
         else exp_drops++;
         if (e.beats != 0) mcmd_q.push_front(e);
      end
   endtask

   function automatic int pending();
      int t = 0;
      for (int c = 0; c < N_CH; c++) t += exp_q[c].size();
      return t;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_cmd(input int vfid, input int len, input logic last);
      logic [REQ_BITS-1:0] rq;
      logic [N_CH-1:0]     exp_v;
      int                  n;
      rq = {$urandom, $urandom, $urandom, $urandom};
      exp_v = '0;
      if (vfid < N_CH) exp_v[vfid] = 1'b1;
      @(negedge aclk);
      bus.s_req_valid = 1'b1;
      bus.s_req_data  = rq;
      bus.s_req_vfid  = CH_BITS'(vfid);
      bus.s_req_len   = LEN_BITS'(len);
      bus.s_req_last  = last;
      #1;
      n = 0;
      while (!bus.s_req_ready && n < 300) begin
         @(negedge aclk);
         #1;
         n++;
      end
      if (bus.s_req_ready) begin
         check("req_valid", bus.m_req_valid, exp_v);
         check("req_data", bus.m_req_data, rq);
         @(posedge aclk);
         model_cmd(vfid, len, last);
      end else begin
         check("req_timeout", bus.s_req_ready, 1'b1);
      end
      #1 bus.s_req_valid = 1'b0;
   endtask

   task automatic send_beat(output int waits);
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      k = {$urandom, $urandom};
      @(negedge aclk);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = d;
      bus.s_axis_tkeep  = k;
      bus.s_axis_tlast  = 1'($urandom_range(0, 1));
      #1;
      waits = 0;
      while (!bus.s_axis_tready && waits < 300) begin
         @(negedge aclk);
         #1;
         waits++;
      end
      if (bus.s_axis_tready) begin
         @(posedge aclk);
         model_beat(d, k);
      end else begin
         check("beat_timeout", bus.s_axis_tready, 1'b1);
      end
      #1 bus.s_axis_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (pending() != 0 && n < 3000) begin
         @(negedge aclk);
         n++;
      end
      check("drain_left", pending(), 0);
   endtask

   always @(negedge aclk) begin
      bus.m_axis_tready = N_CH'($urandom) & ~hold_rdy;
      bus.m_req_ready   = N_CH'($urandom);
   end

   // ---------------- output monitor ----------------
   always begin
      @(negedge aclk);
      #3;
      for (int c = 0; c < N_CH; c++) begin
         if (aresetn && bus.m_req_valid[c] && bus.m_req_ready[c]) seen_req[c]++;
         if (aresetn && bus.m_axis_tvalid[c] && bus.m_axis_tready[c]) begin
            if (exp_q[c].size() == 0) begin
               check($sformatf("ch%0d_extra_beat", c), bus.m_axis_tvalid[c], 1'b0);
            end else begin
               check($sformatf("ch%0d_beat", c),
                     {bus.m_axis_tlast[c], bus.m_axis_tkeep[c*KW +: KW], bus.m_axis_tdata[c*DW +: DW]},
                     exp_q[c].pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int w;
      for (int c = 0; c < N_CH; c++) begin
         exp_req[c]  = 0;
         seen_req[c] = 0;
      end
      bus.s_req_valid = 1'b1;
      bus.s_req_data = '0;
      bus.s_req_vfid = '0;
      bus.s_req_len = LEN_BITS'(64);
      bus.s_req_last = 1'b0;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata = '0;
      bus.s_axis_tkeep = '0;
      bus.s_axis_tlast = 1'b0;

      // reset state, with valids held high
      repeat (3) @(negedge aclk);
      #1;
      check("rst_s_req_ready", bus.s_req_ready, 1'b0);
      check("rst_m_req_valid", bus.m_req_valid, '0);
      check("rst_s_axis_tready", bus.s_axis_tready, 1'b0);
      check("rst_m_axis_tvalid", bus.m_axis_tvalid, '0);
      check("rst_m_wr_rdy", m_wr_rdy, {N_CH{1'b1}});
      check("rst_err", err_bad_vfid, 1'b0);
      check("rst_drop", drop_cnt, 16'd0);
      check("rst_state_idle", dbg_state, 2'd0);
      bus.s_req_valid = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (2) @(negedge aclk);

      // single command: 130 bytes -> 3 beats on ch2, tlast only on the third
      send_cmd(2, 130, 1'b1);
      repeat (3) send_beat(w);
      drain();
      check("t1_req_count_ch2", seen_req[2], exp_req[2]);

      // back-to-back commands switch channels without a bubble
      send_cmd(0, 64, 1'b0);
      send_cmd(3, 128, 1'b1);
      send_beat(w);
      send_beat(w);
      check("b2b_wait_beat2", w, 0);
      send_beat(w);
      check("b2b_wait_beat3", w, 0);
      drain();

      // non-existent channel: beats are swallowed and counted
      send_cmd(5, 200, 1'b0);
      repeat (4) send_beat(w);
      drain();
      check("bad_err", err_bad_vfid, exp_err);
      check("bad_drop_cnt", drop_cnt, 16'(exp_drops));

      // zero-length command consumes no data
      send_cmd(1, 0, 1'b1);
      repeat (4) begin
         @(negedge aclk);
         #1;
         check("zl_tready_low", bus.s_axis_tready, 1'b0);
      end
      send_cmd(3, 64, 1'b1);
      send_beat(w);
      drain();
      check("zl_req_count_ch1", seen_req[1], exp_req[1]);

      // threshold and full: ch0 held, 64 beats fill it
      hold_rdy = 4'b0001;
      send_cmd(0, 66 * 64, 1'b1);
      for (int k = 1; k <= FIFO_DEPTH; k++) begin
         send_beat(w);
         #1;
         check($sformatf("thr_rdy_k%0d", k), m_wr_rdy[0], ((k - 1) <= RDY_THRS));
      end
      @(negedge aclk);
      bus.s_axis_tvalid = 1'b1;
      repeat (4) begin
         #1;
         check("full_stall", bus.s_axis_tready, 1'b0);
         @(negedge aclk);
      end
      bus.s_axis_tvalid = 1'b0;
      check("full_rdy_low", m_wr_rdy[0], 1'b0);
      hold_rdy = '0;
      repeat (2) send_beat(w);
      drain();

      // reset in the middle of a ch1 transfer
      hold_rdy = 4'b0010;
      send_cmd(1, 5 * 64, 1'b1);
      repeat (2) send_beat(w);
      @(negedge aclk);
      aresetn = 1'b0;
      @(posedge aclk);
      #2;
      check("mid_rst_m_axis_tvalid", bus.m_axis_tvalid, '0);
      check("mid_rst_m_req_valid", bus.m_req_valid, '0);
      check("mid_rst_s_axis_tready", bus.s_axis_tready, 1'b0);
      check("mid_rst_err", err_bad_vfid, 1'b0);
      check("mid_rst_drop", drop_cnt, 16'd0);
      check("mid_rst_state", dbg_state, 2'd0);
      check("mid_rst_wr_rdy", m_wr_rdy, {N_CH{1'b1}});
      for (int c = 0; c < N_CH; c++) begin
         exp_q[c].delete();
         exp_req[c]  = 0;
         seen_req[c] = 0;
      end
      mcmd_q.delete();
      exp_drops = 0;
      exp_err = 1'b0;
      hold_rdy = '0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      #1;
      check("post_rst_fifos_empty", bus.m_axis_tvalid, '0);
      send_cmd(1, 100, 1'b1);
      repeat (2) send_beat(w);
      drain();

      // randomized batches with concurrent command and data streams
      for (int b = 0; b < 20; b++) begin
         nc = $urandom_range(1, 6);
         nb = 0;
         for (int i = 0; i < nc; i++) begin
            b_vf[i]   = $urandom_range(0, 6);
            b_len[i]  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 300);
            b_last[i] = 1'($urandom_range(0, 1));
            nb += (b_len[i] + BB - 1) / BB;
         end
         fork
            begin
               for (int i = 0; i < nc; i++) begin
                  repeat ($urandom_range(0, 2)) @(negedge aclk);
                  send_cmd(b_vf[i], b_len[i], b_last[i]);
               end
            end
            begin
               int wj;
               for (int j = 0; j < nb; j++) begin
                  repeat ($urandom_range(0, 1)) @(negedge aclk);
                  send_beat(wj);
               end
            end
         join
         drain();
      end

      repeat (4) @(negedge aclk);
      check("end_err", err_bad_vfid, exp_err);
      check("end_drop_cnt", drop_cnt, 16'(exp_drops));
      check("end_cmds_left", mcmd_q.size(), 0);
      for (int c = 0; c < N_CH; c++) begin
         check($sformatf("end_req_count_ch%0d", c), seen_req[c], exp_req[c]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
